// File: rtl/demux_rx.sv
// demux_rx: receive-side 1:4 byte demultiplexer.
// Spreads a serialized byte stream round-robin over four lanes. Byte n of a
// burst goes to lane n mod 4. Each completed 4-byte group is presented as one
// registered frame. A burst that ends part-way through a frame is reported
// and counted, and its filled lanes are flushed when FLUSH_PARTIAL is set.
module demux_rx #(
  parameter int BW            = 8,
  parameter int FLUSH_PARTIAL = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [BW-1:0]    Entrada,
  input  logic             validEntrada,
  output logic [BW-1:0]    Salida0,
  output logic [BW-1:0]    Salida1,
  output logic [BW-1:0]    Salida2,
  output logic [BW-1:0]    Salida3,
  output logic             validsalida0,
  output logic             validsalida1,
  output logic             validsalida2,
  output logic             validsalida3,
  output logic             frame_valid,
  output logic             partial_err,
  output logic [CNT_W-1:0] partial_cnt
);

  // Two-state controller. IDLE means no burst is active. FILL means a burst
  // is active and ptr selects the lane that the next byte will land in.
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_FILL = 1'b1;

  localparam logic [1:0] LAST_LANE = 2'd3;

  logic             state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;

  // Lanes 0..2 wait in hold registers. Lane 3 never needs one, because the
  // byte that completes a frame goes straight to its output register.
  logic [BW-1:0]    hold_q [3];
  logic [BW-1:0]    hold_d [3];

  // Registered lane outputs and strobes.
  logic [BW-1:0]    sal_q [4];
  logic [BW-1:0]    sal_d [4];
  logic [3:0]       val_q, val_d;
  logic             fv_q, fv_d;
  logic             pe_q, pe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Per-lane values used when a burst ends mid-frame. A lane keeps its held
  // byte only if it was filled before the gap, i.e. its index is below ptr.
  logic [2:0]       keep_lane;
  logic [BW-1:0]    flush_byte [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_flush
      assign keep_lane[gi]  = (ptr_q > 2'(gi));
      assign flush_byte[gi] = keep_lane[gi] ? hold_q[gi] : '0;
    end
  endgenerate

  // Next-state logic: collect bytes, emit full frames, handle burst ends.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    sal_d   = sal_q;
    val_d   = '0;
    fv_d    = 1'b0;
    pe_d    = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        // A new burst always starts on lane 0.
        if (validEntrada) begin
          hold_d[0] = Entrada;
          ptr_d     = 2'd1;
          state_d   = ST_FILL;
        end
      end

      default: begin
        if (validEntrada) begin
          if (ptr_q == LAST_LANE) begin
            // The fourth byte completes the frame. Present all lanes now and
            // stay in FILL, so that the next frame can follow with no gap.
            for (int k = 0; k < 3; k++) begin
              sal_d[k] = hold_q[k];
            end
            sal_d[3] = Entrada;
            val_d    = 4'hF;
            fv_d     = 1'b1;
            ptr_d    = 2'd0;
          end else begin
            for (int k = 0; k < 3; k++) begin
              if (ptr_q == 2'(k)) begin
                hold_d[k] = Entrada;
              end
            end
            ptr_d = ptr_q + 2'd1;
          end
        end else begin
          // A gap ends the burst. When bytes are still pending, the burst
          // ended mid-frame: report it, and optionally flush what was filled.
          if (ptr_q != 2'd0) begin
            pe_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + 1'b1;
            end
            if (FLUSH_PARTIAL != 0) begin
              for (int k = 0; k < 3; k++) begin
                sal_d[k] = flush_byte[k];
                val_d[k] = keep_lane[k];
              end
              sal_d[3] = '0;
              val_d[3] = 1'b0;
            end
          end
          ptr_d   = 2'd0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Control state, hold registers and saturating counter. Reset clears all of
  // them, so a frame in progress is dropped without a partial report.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      for (int k = 0; k < 3; k++) begin
        hold_q[k] <= '0;
      end
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output registers. Strobes last one cycle. Lane data is held until the
  // next frame or flush overwrites it.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        sal_q[k] <= '0;
      end
      val_q <= '0;
      fv_q  <= 1'b0;
      pe_q  <= 1'b0;
    end else begin
      sal_q <= sal_d;
      val_q <= val_d;
      fv_q  <= fv_d;
      pe_q  <= pe_d;
    end
  end

  assign Salida0      = sal_q[0];
  assign Salida1      = sal_q[1];
  assign Salida2      = sal_q[2];
  assign Salida3      = sal_q[3];
  assign validsalida0 = val_q[0];
  assign validsalida1 = val_q[1];
  assign validsalida2 = val_q[2];
  assign validsalida3 = val_q[3];
  assign frame_valid  = fv_q;
  assign partial_err  = pe_q;
  assign partial_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_rx.sv
// Testbench for demux_rx. Two instances receive the same stimulus:
//   dut_a: FLUSH_PARTIAL=1, CNT_W=8
//   dut_b: FLUSH_PARTIAL=0, CNT_W=2
// The bench runs a directed vector table, a counter saturation sequence, and
// a randomized phase that is checked against a queue-based reference model.
module tb_demux_rx;

  logic       clk_4f       = 1'b0;
  logic       reset        = 1'b1;
  logic       validEntrada = 1'b0;
  logic [7:0] Entrada      = 8'h00;

  always #5 clk_4f = ~clk_4f;

  logic [7:0] sal [2][4];
  logic       vs  [2][4];
  logic       fv  [2];
  logic       pe  [2];
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  demux_rx #(.BW(8), .FLUSH_PARTIAL(1), .CNT_W(8)) dut_a (
    .clk_4f(clk_4f), .reset(reset), .Entrada(Entrada), .validEntrada(validEntrada),
    .Salida0(sal[0][0]), .Salida1(sal[0][1]), .Salida2(sal[0][2]), .Salida3(sal[0][3]),
    .validsalida0(vs[0][0]), .validsalida1(vs[0][1]),
    .validsalida2(vs[0][2]), .validsalida3(vs[0][3]),
    .frame_valid(fv[0]), .partial_err(pe[0]), .partial_cnt(cnt_a)
  );

  demux_rx #(.BW(8), .FLUSH_PARTIAL(0), .CNT_W(2)) dut_b (
    .clk_4f(clk_4f), .reset(reset), .Entrada(Entrada), .validEntrada(validEntrada),
    .Salida0(sal[1][0]), .Salida1(sal[1][1]), .Salida2(sal[1][2]), .Salida3(sal[1][3]),
    .validsalida0(vs[1][0]), .validsalida1(vs[1][1]),
    .validsalida2(vs[1][2]), .validsalida3(vs[1][3]),
    .frame_valid(fv[1]), .partial_err(pe[1]), .partial_cnt(cnt_b)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc_n   = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc_n, act, exp);
  endtask

  // Reference model. A burst is a queue of pending bytes. It becomes a frame
  // once four bytes have arrived, and a partial frame if a gap arrives first.
  logic [7:0]     m_sal [2][4];
  logic [3:0]     m_vs  [2];
  bit             m_fv  [2];
  bit             m_pe  [2];
  int             m_cnt [2];
  byte unsigned   pend [$];
  int             cnt_max [2] = '{255, 3};
  bit             m_flush [2] = '{1'b1, 1'b0};

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    for (int c = 0; c < 2; c++) begin
      m_vs[c] = 4'h0; m_fv[c] = 1'b0; m_pe[c] = 1'b0;
    end
    if (r) begin
      pend.delete();
      for (int c = 0; c < 2; c++) begin
        m_cnt[c] = 0;
        for (int k = 0; k < 4; k++) m_sal[c][k] = 8'h00;
      end
    end else if (v) begin
      pend.push_back(d);
      if (pend.size() == 4) begin
        for (int c = 0; c < 2; c++) begin
          for (int k = 0; k < 4; k++) m_sal[c][k] = pend[k];
          m_vs[c] = 4'hF;
          m_fv[c] = 1'b1;
        end
        pend.delete();
      end
    end else if (pend.size() > 0) begin
      for (int c = 0; c < 2; c++) begin
        m_pe[c]  = 1'b1;
        m_cnt[c] = (m_cnt[c] + 1 > cnt_max[c]) ? cnt_max[c] : m_cnt[c] + 1;
        if (m_flush[c]) begin
          for (int k = 0; k < 4; k++) begin
            m_sal[c][k] = (k < pend.size()) ? pend[k] : 8'h00;
            m_vs[c][k]  = (k < pend.size());
          end
        end
      end
      pend.delete();
    end
  endtask

  // One clock cycle: drive the inputs, step the model at the edge, and
  // return 1 time unit after the edge, so the checks sample away from it.
  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    reset = r; validEntrada = v; Entrada = d;
    @(posedge clk_4f);
    model_step(r, v, d);
    cyc_n++;
    #1;
  endtask

  function automatic logic [3:0] get_vs(input int c);
    return {vs[c][3], vs[c][2], vs[c][1], vs[c][0]};
  endfunction

  function automatic int unsigned get_cnt(input int c);
    return (c == 0) ? int'(cnt_a) : int'(cnt_b);
  endfunction

  task automatic chk_model(input int c);
    for (int k = 0; k < 4; k++)
      chk($sformatf("m%0d_salida%0d", c, k), sal[c][k], m_sal[c][k]);
    chk($sformatf("m%0d_valids", c), get_vs(c), m_vs[c]);
    chk($sformatf("m%0d_frame_valid", c), fv[c], m_fv[c]);
    chk($sformatf("m%0d_partial_err", c), pe[c], m_pe[c]);
    chk($sformatf("m%0d_partial_cnt", c), get_cnt(c), m_cnt[c]);
  endtask

  typedef struct {
    logic       r, v;
    logic [7:0] d;
    logic [7:0] s0, s1, s2, s3;
    logic [3:0] vs;
    logic       fv, pe;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic [7:0] s0, input logic [7:0] s1,
                     input logic [7:0] s2, input logic [7:0] s3,
                     input logic [3:0] vv, input logic f, input logic p,
                     input logic [7:0] cn);
    vec_t e;
    e.r = r; e.v = v; e.d = d; e.s0 = s0; e.s1 = s1; e.s2 = s2; e.s3 = s3;
    e.vs = vv; e.fv = f; e.pe = p; e.cnt = cn;
    tbl.push_back(e);
  endtask

  initial begin
    // Reset for 2 cycles with garbage on the inputs.
    add(1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0);
    add(1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0);
    // One full frame, whose data is then held for 5 idle cycles.
    add(0, 1, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0);
    add(0, 1, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0);
    add(0, 1, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0);
    add(0, 1, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 4'hF, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 4'h0, 0, 0, 0);
    // Two back-to-back frames, 0xA0..0xA7.
    for (int i = 0; i < 8; i++) begin
      if (i < 3)       add(0, 1, 8'(8'hA0 + i), 8'h11, 8'h22, 8'h33, 8'h44, 4'h0, 0, 0, 0);
      else if (i == 3) add(0, 1, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'hF, 1, 0, 0);
      else if (i < 7)  add(0, 1, 8'(8'hA0 + i), 8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'h0, 0, 0, 0);
      else             add(0, 1, 8'hA7, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 4'hF, 1, 0, 0);
    end
    add(0, 0, 8'h00, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 4'h0, 0, 0, 0);
    // A partial frame of 3 bytes, then a gap that flushes it.
    add(0, 1, 8'h01, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 4'h0, 0, 0, 0);
    add(0, 1, 8'h02, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 4'h0, 0, 0, 0);
    add(0, 1, 8'h03, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 4'h0, 0, 0, 0);
    add(0, 0, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 4'h7, 0, 1, 1);
    add(0, 0, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 4'h0, 0, 0, 1);
    // The next burst realigns to lane 0.
    add(0, 1, 8'h10, 8'h01, 8'h02, 8'h03, 8'h00, 4'h0, 0, 0, 1);
    add(0, 1, 8'h11, 8'h01, 8'h02, 8'h03, 8'h00, 4'h0, 0, 0, 1);
    add(0, 1, 8'h12, 8'h01, 8'h02, 8'h03, 8'h00, 4'h0, 0, 0, 1);
    add(0, 1, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13, 4'hF, 1, 0, 1);
    add(0, 0, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 4'h0, 0, 0, 1);
    // Reset after 2 bytes: the frame is dropped silently.
    add(0, 1, 8'h55, 8'h10, 8'h11, 8'h12, 8'h13, 4'h0, 0, 0, 1);
    add(0, 1, 8'h56, 8'h10, 8'h11, 8'h12, 8'h13, 4'h0, 0, 0, 1);
    add(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0);
    add(0, 1, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0);
    add(0, 1, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0);
    add(0, 1, 8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0);
    add(0, 1, 8'h58, 8'h55, 8'h56, 8'h57, 8'h58, 4'hF, 1, 0, 0);
    add(0, 0, 8'h00, 8'h55, 8'h56, 8'h57, 8'h58, 4'h0, 0, 0, 0);

    // Directed phase: dut_a is checked against the table, dut_b against the model.
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].d);
      $display("vec %0d: r=%0b v=%0b d=%02h -> salida=%02h %02h %02h %02h valids=%h fv=%0b pe=%0b cnt=%0d",
               i, tbl[i].r, tbl[i].v, tbl[i].d, sal[0][0], sal[0][1], sal[0][2], sal[0][3],
               get_vs(0), fv[0], pe[0], cnt_a);
      chk("tbl_salida0", sal[0][0], tbl[i].s0);
      chk("tbl_salida1", sal[0][1], tbl[i].s1);
      chk("tbl_salida2", sal[0][2], tbl[i].s2);
      chk("tbl_salida3", sal[0][3], tbl[i].s3);
      chk("tbl_valids", get_vs(0), tbl[i].vs);
      chk("tbl_frame_valid", fv[0], tbl[i].fv);
      chk("tbl_partial_err", pe[0], tbl[i].pe);
      chk("tbl_partial_cnt", cnt_a, tbl[i].cnt);
      chk_model(1);
    end

    // Counter saturation: 5 single-byte bursts, each followed by a gap.
    drive(1, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'(i + 1));
      drive(0, 0, 8'h00);
      $display("sat burst %0d: pe_b=%0b cnt_b=%0d pe_a=%0b cnt_a=%0d",
               i, pe[1], cnt_b, pe[0], cnt_a);
      chk("sat_pe_b", pe[1], 1);
      chk("sat_cnt_b", cnt_b, (i < 3) ? i + 1 : 3);
      chk("sat_novalid_b", get_vs(1), 0);
      chk("sat_pe_a", pe[0], 1);
      chk("sat_cnt_a", cnt_a, i + 1);
      chk("sat_flush_valid_a", get_vs(0), 4'h1);
      chk("sat_flush_data_a", sal[0][0], i + 1);
      chk("sat_flush_zero_a", sal[0][1], 0);
    end

    // Randomized phase: mostly-valid traffic with gaps and occasional resets.
    drive(1, 0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
      chk_model(0);
      chk_model(1);
    end
    $display("random phase: %0d cycles", 3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
